scr1_ahb_ram_resp: RTL
======================

SCR1_AHB_RAM_RESP -- requirements
Module: scr1_ahb_ram_resp

Interface
REQ-001 SHALL have parameter MEM_POWER_SIZE, default 12, giving memory size as 2**MEM_POWER_SIZE bytes.
REQ-002 SHALL have parameter WAIT_STATES, default 0 (range 0-15), giving the number of hready-low cycles inserted per data phase.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port htrans  in  2  AHB-Lite transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-006 SHALL have port hsize  in  3  transfer size: 000 byte, 001 half, 010 word; other values are illegal.
REQ-007 SHALL have port haddr  in  32  byte address.
REQ-008 SHALL have port hwrite  in  1  1 = write, 0 = read.
REQ-009 SHALL have port hwdata  in  32  write data, valid during the write data phase.
REQ-010 SHALL have port hready  out  1  transfer done / responder ready.
REQ-011 SHALL have port hrdata  out  32  read data.
REQ-012 SHALL have port hresp  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-013 SHALL accept an address phase only on a rising edge where hready=1 and htrans[1]=1; IDLE and BUSY are accepted with zero wait and an OKAY response.
REQ-014 SHALL register haddr, hsize and hwrite at acceptance and use only the registered copies during the following data phase.
REQ-015 SHALL implement states IDLE, WAIT, LAST, ERR1, ERR2.
- IDLE -> WAIT when WAIT_STATES>0.
- IDLE -> LAST when WAIT_STATES=0.
- WAIT -> LAST when the counter reaches 1.
- LAST -> next state per REQ-013.
REQ-016 SHALL load the wait counter with WAIT_STATES at acceptance, decrement it each WAIT cycle, and drive hready=0 in WAIT and hready=1 in LAST.
REQ-017 SHALL perform each transfer as a single transfer; SEQ is handled exactly like NONSEQ and bursts need no special handling.
REQ-018 SHALL commit a write on the clock edge that ends LAST, updating only the byte lanes selected by hsize and registered haddr[1:0] (byte: lane addr[1:0]; half: lanes addr[1]*2+{0,1}; word: all four).
REQ-019 SHALL drive hrdata in LAST of a read with the full aligned word at registered address, read combinationally from the array, and drive hrdata=0 in all other cycles.
REQ-020 SHALL return the just-written data to a read whose address phase overlaps the preceding write's data phase to the same word.
REQ-021 SHALL index the array with haddr[MEM_POWER_SIZE-1:2].
REQ-022 SHALL keep hresp=0 in IDLE, WAIT and LAST.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force state=IDLE, hready=1, hresp=0, hrdata=0, wait counter=0 and registered controls to 0.
REQ-024 SHALL abandon a transfer that reset interrupts mid-data-phase; a write not yet committed SHALL NOT modify memory.
REQ-025 SHALL NOT clear memory contents on reset.

Configuration
REQ-026 SHALL use the macro SCR1_AHB_RESP_ERR_EN.
REQ-027 With SCR1_AHB_RESP_ERR_EN defined:
- SHALL treat as an error any accepted transfer with haddr[31:MEM_POWER_SIZE]!=0, misaligned address (half with addr[0]=1, word with addr[1:0]!=0), or illegal hsize.
- Error sequence SHALL be ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1), with no memory write.
- SHALL honour the wait states (WAIT) before ERR1.
REQ-028 Without SCR1_AHB_RESP_ERR_EN:
- hresp SHALL be constant 0 and ERR1/ERR2 SHALL be absent.
- Upper address bits SHALL be ignored, so addresses wrap modulo memory size.
- Misaligned addresses SHALL be aligned down to the size.
- Illegal hsize SHALL be treated as word.

Verification
REQ-029 WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 -> hready stays 1, hrdata=0xDEADBEEF in read data phase, hresp=0.
REQ-030 WAIT_STATES=3: read @0x0 -> hready low exactly 3 cycles, then 1 with data; next address phase held and not accepted until hready=1.
REQ-031 Byte write 0xAA @0x13 over word 0x11223344 @0x10 -> read @0x10 returns 0xAA223344.
REQ-032 Back-to-back write 0x5A5A5A5A @0x20 with immediately pipelined read @0x20 -> read returns 0x5A5A5A5A.
REQ-033 With SCR1_AHB_RESP_ERR_EN: word read @0x2 -> ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); write @0x1000 (MEM_POWER_SIZE=12) -> error, memory unchanged. Without the macro: write @0x1000 aliases @0x0.
REQ-034 rst_n asserted in the WAIT cycle of a write @0x40 (WAIT_STATES=2) -> hready=1, hresp=0, hrdata=0 immediately; word @0x40 unchanged after reset release.

Source files
------------

// File: rtl/scr1_ahb_ram_resp.sv
// scr1_ahb_ram_resp: AHB-Lite single-port RAM responder with WAIT_STATES hready-low cycles per data phase.
// Define SCR1_AHB_RESP_ERR_EN to answer out-of-range, misaligned or bad-size transfers with a two-cycle ERROR.
module scr1_ahb_ram_resp #(
  parameter int MEM_POWER_SIZE = 12,
  parameter int WAIT_STATES    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic [31:0] hrdata,
  output logic        hresp
);
  localparam int AW = MEM_POWER_SIZE;
  localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, LAST = 3'd2;
  logic [2:0]    state_q, state_d, acc_st, end_st;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          accept, unused_in;
  logic [3:0]    be;
  logic [31:0]   mem [2**(AW-2)];
  assign accept = hready & htrans[1];
  assign unused_in = ^{haddr[31:AW], htrans[0]};
`ifdef SCR1_AHB_RESP_ERR_EN
  localparam logic [2:0] ERR1 = 3'd3, ERR2 = 3'd4;
  logic fail, fail_q, fail_d;
  assign fail = (|haddr[31:AW]) | hsize[2] | (&hsize[1:0]) |
                (hsize == 3'b001 & haddr[0]) | (hsize == 3'b010 & |haddr[1:0]);
  assign fail_d = accept ? fail : fail_q;
  assign acc_st = fail ? ERR1 : LAST;
  assign end_st = fail_q ? ERR1 : LAST;
  assign hresp  = (state_q == ERR1) | (state_q == ERR2);
  assign hready = (state_q != WAIT) & (state_q != ERR1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fail_q <= 1'b0;
    else fail_q <= fail_d;
`else
  assign acc_st = LAST;
  assign end_st = LAST;
  assign hresp  = 1'b0;
  assign hready = state_q != WAIT;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    if (accept) begin
      addr_d  = haddr[AW-1:0];
      size_d  = hsize;
      write_d = hwrite;
      cnt_d   = 4'(WAIT_STATES);
      state_d = (WAIT_STATES > 0) ? WAIT : acc_st;
    end else if (hready) state_d = IDLE;
`ifdef SCR1_AHB_RESP_ERR_EN
    else if (state_q == ERR1) state_d = ERR2;
`endif
    else begin
      cnt_d   = cnt_q - 4'd1;
      state_d = (cnt_q == 4'd1) ? end_st : WAIT;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  // misaligned accesses fall onto their size-aligned lanes; any other size is a word
  assign be = size_q == 3'd0 ? 4'b0001 << addr_q[1:0] :
              size_q == 3'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_ff @(posedge clk)
    if (state_q == LAST && write_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[AW-1:2]][8*i +: 8] <= hwdata[8*i +: 8];
  assign hrdata = (state_q == LAST && !write_q) ? mem[addr_q[AW-1:2]] : '0;
endmodule
